pipeline_hazard_ctrl: RTL
=========================

# pipeline_hazard_ctrl

Hazard control unit for the 5-stage MIPS pipeline, the producer-side counterpart of the EX/MEM and MEM/WB forwarding path. Forwarding covers every ALU result, so this block handles only hazards it cannot resolve. It stalls on load-use dependences and on multi-cycle MULT/DIV (HI/LO) conflicts, flushes on taken branches resolved in EX, and counts stall cycles for performance monitoring.

## Interface
Parameters:
- MULDIV_CYCLES, 4: cycles HI/LO stays busy after a MULT/DIV leaves ID (legal range 1..15)
- CNT_W, 32: width of the stall-cycle counter

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- id_rs / id_rt  input  5 each  source register addresses of the instruction in ID
- id_use_rs / id_use_rt  input  1 each  the ID instruction actually reads rs / rt
- id_is_muldiv  input  1  ID instruction is MULT/MULTU/DIV/DIVU
- id_uses_hilo  input  1  ID instruction is MFHI/MFLO/MTHI/MTLO
- id_ex_rd  input  5  destination register of the instruction in EX
- id_ex_memread  input  1  the EX instruction is a load
- ex_branch_taken  input  1  branch/jump in EX resolved taken this cycle
- pc_write_en  output  1  PC may update
- if_id_write_en  output  1  IF/ID register may load
- if_id_flush  output  1  IF/ID loads a bubble
- id_ex_flush  output  1  ID/EX loads a bubble
- stall_reason  output  2  00 none, 01 load-use, 10 muldiv, 11 both
- muldiv_busy  output  1  HI/LO unit busy
- stall_cycles  output  CNT_W  saturating count of stalled cycles

## Operation
- load_use = id_ex_memread & (id_ex_rd != 0) & ((id_use_rs & id_rs == id_ex_rd) | (id_use_rt & id_rt == id_ex_rd)).
- md_hazard = muldiv_busy & (id_is_muldiv | id_uses_hilo).
- stall = (load_use | md_hazard) & ~ex_branch_taken.
- The branch flush has priority over both hazards.
  - On ex_branch_taken: pc_write_en=1, if_id_write_en=1, if_id_flush=1, id_ex_flush=1, and stall_reason=00.
- On stall: pc_write_en=0, if_id_write_en=0, if_id_flush=0, id_ex_flush=1.
  - stall_reason = {md_hazard, load_use}.
- Otherwise: pc_write_en=1, if_id_write_en=1, both flushes 0, stall_reason=00.
- Busy counter busy_cnt (4 bits):
  - launch = id_is_muldiv & ~stall & ~ex_branch_taken.
  - On launch, load MULDIV_CYCLES.
  - Else, if busy_cnt != 0, decrement by 1.
  - muldiv_busy = (busy_cnt != 0).
- A flushed MULT/DIV never launches.
- stall_cycles increments by 1 in each cycle where stall=1 and saturates at all-ones (no wrap).

## Timing
- Hazard outputs (pc_write_en, if_id_write_en, flushes, stall_reason) are combinational from inputs and registered state, valid in the same cycle.
- Registered state: busy_cnt and stall_cycles.
- While rst_n=0, asynchronously and regardless of inputs:
  - busy_cnt=0, muldiv_busy=0, stall_cycles=0.
  - pc_write_en=0, if_id_write_en=0, if_id_flush=1, id_ex_flush=1, stall_reason=00.
- After deassertion, outputs follow the rules from the first cycle.
- Load-use stall lasts exactly 1 cycle. The load moves to MEM and forwarding supplies the value from MEM/WB.
- MULT/DIV leaving ID at cycle t:
  - muldiv_busy=1 in cycles t+1..t+MULDIV_CYCLES.
  - A dependent HI/LO or MULT/DIV instruction held in ID proceeds at cycle t+MULDIV_CYCLES+1.
- Reset asserted mid-operation clears busy_cnt immediately; any in-flight HI/LO result is abandoned.
- Simultaneous load-use and md_hazard: a single stall with stall_reason=11. That cycle still decrements busy_cnt.
- rs or rt equal to 0 never produces a load-use stall.

## Test plan
- Load to $t1 in EX (id_ex_memread=1, id_ex_rd=9), ID reads rs=9 with id_use_rs=1:
  - pc_write_en=0, if_id_write_en=0, id_ex_flush=1, stall_reason=01 for 1 cycle; stall_cycles=1.
  - Next cycle, with EX holding the bubble: no stall.
- Same stimulus with id_ex_rd=0, or id_use_rs=0 -> no stall, stall_reason=00.
- MULT launches at cycle 5 (MULDIV_CYCLES=4), MFLO in ID from cycle 6:
  - stalls in cycles 6-9 with stall_reason=10.
  - Proceeds at cycle 10; stall_cycles=4.
- Load-use condition and ex_branch_taken=1 together:
  - pc_write_en=1, if_id_flush=1, id_ex_flush=1, stall_reason=00, stall_cycles unchanged.
- MULT in ID with ex_branch_taken=1 -> muldiv_busy stays 0 next cycle.
- Pulse rst_n low while busy_cnt=3 -> muldiv_busy=0 and stall_cycles=0 immediately; a MFHI in ID after release does not stall.
- Preload stall_cycles to all-ones (CNT_W=4 build) and apply a stall -> stays at 15.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard control for the 5-stage pipeline: load-use and HI/LO busy stalls, taken-branch
// flushes, and a saturating stall-cycle counter for performance monitoring.
module pipeline_hazard_ctrl #(
  parameter int MULDIV_CYCLES = 4,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_is_muldiv,
  input  logic             id_uses_hilo,
  input  logic [4:0]       id_ex_rd,
  input  logic             id_ex_memread,
  input  logic             ex_branch_taken,
  output logic             pc_write_en,
  output logic             if_id_write_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic [1:0]       stall_reason,
  output logic             muldiv_busy,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [3:0] MdLoad = 4'(MULDIV_CYCLES);

  logic [3:0]       busyCnt;
  logic [CNT_W-1:0] stallCnt;
  logic             loadUse;
  logic             mdHazard;
  logic             stall;
  logic             launch;

  // $zero is never a real producer, so a load targeting it cannot create a dependence.
  assign loadUse = id_ex_memread && (id_ex_rd != 5'd0) &&
                   ((id_use_rs && (id_rs == id_ex_rd)) ||
                    (id_use_rt && (id_rt == id_ex_rd)));
  assign mdHazard    = (busyCnt != 4'd0) && (id_is_muldiv || id_uses_hilo);
  assign stall       = (loadUse || mdHazard) && !ex_branch_taken;
  assign launch      = id_is_muldiv && !stall && !ex_branch_taken;
  assign muldiv_busy = (busyCnt != 4'd0);
  assign stall_cycles = stallCnt;

  // Branch flush outranks both hazards; reset holds the pipeline frozen and bubbled.
  always_comb begin
    pc_write_en    = 1'b1;
    if_id_write_en = 1'b1;
    if_id_flush    = 1'b0;
    id_ex_flush    = 1'b0;
    stall_reason   = 2'b00;
    if (!rst_n) begin
      pc_write_en    = 1'b0;
      if_id_write_en = 1'b0;
      if_id_flush    = 1'b1;
      id_ex_flush    = 1'b1;
    end else if (ex_branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (stall) begin
      pc_write_en    = 1'b0;
      if_id_write_en = 1'b0;
      id_ex_flush    = 1'b1;
      stall_reason   = {mdHazard, loadUse};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busyCnt  <= 4'd0;
      stallCnt <= '0;
    end else begin
      if (launch) begin
        busyCnt <= MdLoad;
      end else if (busyCnt != 4'd0) begin
        busyCnt <= busyCnt - 4'd1;
      end
      if (stall && (stallCnt != {CNT_W{1'b1}})) begin
        stallCnt <= stallCnt + CNT_W'(1);
      end
    end
  end

endmodule
